// File: rtl/ctc_bus_master.sv
// A&R bus master: word-time counter, instruction fetch serializer, ws field mask and carry capture.
// Optional T0 alignment check is enabled with `define CTC_START_CHECK_EN.
module ctc_bus_master #(
    parameter int WORD_BITS = 56
) (
    input  logic       cph2,
    input  logic       rst_n,
    input  logic       inst_valid,
    input  logic [9:0] inst_data,
    output logic       inst_ready,
    input  logic [3:0] ptr,
    input  logic       carry,
    input  logic       start,
    output logic       sync,
    output logic       is,
    output logic       ws,
    output logic       carry_flag,
    output logic       carry_vld,
    output logic       align_err
);
    localparam logic [5:0] BT_LAST  = 6'(WORD_BITS - 1);
    localparam logic [5:0] BT_XFER  = 6'd44;
    localparam logic [5:0] FETCH_LO = 6'd45;
    localparam logic [5:0] FETCH_HI = 6'd54;
    localparam logic [1:0] TYPE_ARITH = 2'b10;

    logic [5:0] bt_r, bt_nxt;
    logic [3:0] digit;
    logic       end_xfer, end_word, fire, in_fetch;
    logic       pend_full;
    logic [9:0] pend_inst, fetch_inst, fetch_n;
    logic [3:0] pend_ptr, fetch_ptr, fetch_ptr_n, exec_ptr, exec_ptr_n;
    logic [4:0] exec_sel, exec_n;   // only type and field matter once executing
    logic       ws_n, is_n;

    assign inst_ready = !pend_full;
    assign fire       = inst_valid && !pend_full;
    assign end_xfer   = (bt_r == BT_XFER);
    assign end_word   = (bt_r == BT_LAST);

    // Outputs are registered from the next bit time, so next-state register
    // contents are used to avoid a one-cycle lag at the transfer edges.
    always_comb begin
        bt_nxt      = end_word ? 6'd0 : bt_r + 6'd1;
        digit       = bt_nxt[5:2];
        fetch_n     = fetch_inst;
        fetch_ptr_n = fetch_ptr;
        if (end_xfer) begin
            fetch_n     = pend_full ? pend_inst : 10'h000;
            fetch_ptr_n = pend_full ? pend_ptr  : 4'd0;
        end
        exec_n     = end_word ? fetch_inst[4:0] : exec_sel;
        exec_ptr_n = end_word ? fetch_ptr       : exec_ptr;
        in_fetch   = (bt_nxt >= FETCH_LO) && (bt_nxt <= FETCH_HI);
        is_n       = in_fetch && fetch_n[4'(bt_nxt - FETCH_LO)];
    end

    always_comb begin
        ws_n = 1'b0;
        if (exec_n[1:0] == TYPE_ARITH) begin
            case (exec_n[4:2])
                3'b000: ws_n = (digit == exec_ptr_n);
                3'b001: ws_n = (digit >= 4'd3) && (digit <= 4'd12);
                3'b010: ws_n = (digit <= 4'd2);
                3'b011: ws_n = 1'b1;
                3'b100: ws_n = (digit <= exec_ptr_n);
                3'b101: ws_n = (digit >= 4'd3);
                3'b110: ws_n = (digit == 4'd2);
                3'b111: ws_n = (digit == 4'd13);
            endcase
        end
    end

    always_ff @(posedge cph2) begin
        if (!rst_n) begin
            bt_r       <= 6'd0;
            pend_full  <= 1'b0;
            pend_inst  <= 10'h000;
            pend_ptr   <= 4'd0;
            fetch_inst <= 10'h000;
            fetch_ptr  <= 4'd0;
            exec_sel   <= 5'd0;
            exec_ptr   <= 4'd0;
            sync       <= 1'b0;
            is         <= 1'b0;
            ws         <= 1'b0;
            carry_flag <= 1'b0;
            carry_vld  <= 1'b0;
        end else begin
            bt_r       <= bt_nxt;
            fetch_inst <= fetch_n;
            fetch_ptr  <= fetch_ptr_n;
            exec_sel   <= exec_n;
            exec_ptr   <= exec_ptr_n;
            sync       <= in_fetch;
            is         <= is_n;
            ws         <= ws_n;
            // A fire on the transfer edge refills the slot after the old contents move on.
            if (fire) begin
                pend_full <= 1'b1;
                pend_inst <= inst_data;
                pend_ptr  <= ptr;
            end else if (end_xfer) begin
                pend_full <= 1'b0;
            end
            carry_vld <= 1'b0;
            if (end_word && exec_sel[1:0] == TYPE_ARITH) begin
                carry_flag <= carry;
                carry_vld  <= 1'b1;
            end
        end
    end

`ifdef CTC_START_CHECK_EN
    always_ff @(posedge cph2) begin
        if (!rst_n)
            align_err <= 1'b0;
        else if (start != (bt_r == 6'd0))
            align_err <= 1'b1;
    end
`else
    logic unused_start;
    assign unused_start = start;
    assign align_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ctc_bus_master.sv
// Directed bench for ctc_bus_master: walks word by word, recording per-bit-time
// output vectors and comparing them to hand-derived masks.
module tb_ctc_bus_master;
    logic       cph2 = 1'b0;
    logic       rst_n = 1'b0;
    logic       inst_valid = 1'b0;
    logic [9:0] inst_data = 10'h000;
    logic [3:0] ptr = 4'd0;
    logic       carry = 1'b0;
    logic       start = 1'b0;
    logic       inst_ready, sync, is, ws, carry_flag, carry_vld, align_err;

    ctc_bus_master dut (
        .cph2(cph2), .rst_n(rst_n), .inst_valid(inst_valid), .inst_data(inst_data),
        .inst_ready(inst_ready), .ptr(ptr), .carry(carry), .start(start),
        .sync(sync), .is(is), .ws(ws), .carry_flag(carry_flag),
        .carry_vld(carry_vld), .align_err(align_err)
    );

    always #5 cph2 = ~cph2;

    int n_chk = 0;
    int n_fail = 0;
    int bt = 0;
    int fire1, fire2;
    logic [63:0] ws_v, is_v, sync_v, rdy_v, cvld_v;
    logic cflag_end;
    logic exp_align;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_sync"}, 64'(sync), 64'd0);
        chk({tag, "_is"}, 64'(is), 64'd0);
        chk({tag, "_ws"}, 64'(ws), 64'd0);
        chk({tag, "_ready"}, 64'(inst_ready), 64'd1);
        chk({tag, "_cflag"}, 64'(carry_flag), 64'd0);
        chk({tag, "_cvld"}, 64'(carry_vld), 64'd0);
        chk({tag, "_align"}, 64'(align_err), 64'd0);
    endtask

    // One word of 56 bit times; optional offer(s), carry at bt 55, reset and start pulse.
    task automatic word(input logic [9:0] d1, input logic [3:0] p1, input int at1,
                        input logic two, input logic [9:0] d2, input logic [3:0] p2,
                        input logic cy, input int rst_at, input int start_bt);
        int st = 0;
        int nst;
        ws_v = '0; is_v = '0; sync_v = '0; rdy_v = '0; cvld_v = '0;
        fire1 = -1; fire2 = -1;
        for (int k = 0; k < 56; k++) begin
            ws_v[bt] = ws; is_v[bt] = is; sync_v[bt] = sync;
            rdy_v[bt] = inst_ready; cvld_v[bt] = carry_vld; cflag_end = carry_flag;
            if (bt == at1) st = 1;
            nst = st;
            inst_valid = 1'b0;
            if (st == 1) begin
                inst_valid = 1'b1; inst_data = d1; ptr = p1;
                if (inst_ready) begin fire1 = bt; nst = two ? 2 : 0; end
            end else if (st == 2) begin
                inst_valid = 1'b1; inst_data = d2; ptr = p2;
                if (inst_ready) begin fire2 = bt; nst = 0; end
            end
            carry = (bt == 55) ? cy : 1'b0;
            start = (bt == 0) || (bt == start_bt);
            if (bt == rst_at) begin
                rst_n = 1'b0;
                @(posedge cph2); #1;
                chk_reset("midrst");
                rst_n = 1'b1;
                inst_valid = 1'b0;
                bt = 0;
                return;
            end
            @(posedge cph2); #1;
            st = nst;
            bt = (bt + 1) % 56;
        end
        inst_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge cph2);
        #1;
        chk_reset("por");
        rst_n = 1'b1;
        bt = 0;

        // W0: idle word
        word(10'h000, 4'd0, -1, 1'b0, 10'h000, 4'd0, 1'b0, -1, -1);
        chk("w0_sync", sync_v, rng(45, 54));
        chk("w0_is", is_v, 64'd0);
        chk("w0_ws", ws_v, 64'd0);
        chk("w0_ready", rdy_v, rng(0, 55));
        chk("w0_cvld", cvld_v, 64'd0);

        // W1: A=A+1 field W offered at bt 10
        word(10'b11111_011_10, 4'd0, 10, 1'b0, 10'h000, 4'd0, 1'b0, -1, -1);
        chk("w1_is", is_v, rng(46, 48) | rng(50, 54));
        chk("w1_sync", sync_v, rng(45, 54));
        chk("w1_ready", rdy_v, rng(0, 10) | rng(45, 55));
        chk("w1_fire", 64'(fire1), 64'd10);

        // W2: execute W; offer WP ptr=5
        word(10'b00000_100_10, 4'd5, 5, 1'b0, 10'h000, 4'd0, 1'b0, -1, -1);
        chk("w2_ws_W", ws_v, rng(0, 55));

        // W3: execute WP ptr=5; offer P ptr=13
        word(10'b00000_000_10, 4'd13, 5, 1'b0, 10'h000, 4'd0, 1'b0, -1, -1);
        chk("w3_ws_WP5", ws_v, rng(0, 23));
        chk("w3_cvld", cvld_v, rng(0, 0));
        chk("w3_cflag", 64'(cflag_end), 64'd0);

        // W4: execute P ptr=13; offer P ptr=15
        word(10'b00000_000_10, 4'd15, 5, 1'b0, 10'h000, 4'd0, 1'b0, -1, -1);
        chk("w4_ws_P13", ws_v, rng(52, 55));

        // W5: execute P ptr=15; offer M
        word(10'b00000_001_10, 4'd0, 5, 1'b0, 10'h000, 4'd0, 1'b0, -1, -1);
        chk("w5_ws_P15", ws_v, 64'd0);

        // W6: execute M with carry=1 at bt 55; offer misc
        word(10'b00000_001_00, 4'd0, 5, 1'b0, 10'h000, 4'd0, 1'b1, -1, -1);
        chk("w6_ws_M", ws_v, rng(12, 51));

        // W7: execute misc, carry=0 at bt 55 must be ignored
        word(10'h000, 4'd0, -1, 1'b0, 10'h000, 4'd0, 1'b0, -1, -1);
        chk("w7_cvld", cvld_v, rng(0, 0));
        chk("w7_cflag", 64'(cflag_end), 64'd1);
        chk("w7_ws_misc", ws_v, 64'd0);

        // W8: two offers back-to-back from bt 20 (X then W)
        word(10'b00000_010_10, 4'd0, 20, 1'b1, 10'b00000_011_10, 4'd0, 1'b0, -1, -1);
        chk("w8_cvld", cvld_v, 64'd0);
        chk("w8_cflag", 64'(cflag_end), 64'd1);
        chk("w8_fire1", 64'(fire1), 64'd20);
        chk("w8_fire2", 64'(fire2), 64'd45);
        chk("w8_ready", rdy_v, rng(0, 20) | rng(45, 45));
        chk("w8_is", is_v, rng(46, 46) | rng(48, 48));

        // W9: execute X, fetch second (W)
        word(10'h000, 4'd0, -1, 1'b0, 10'h000, 4'd0, 1'b0, -1, -1);
        chk("w9_ws_X", ws_v, rng(0, 11));
        chk("w9_is", is_v, rng(46, 48));
        chk("w9_cvld", cvld_v, 64'd0);

        // W10: execute W, reset at bt 30
        word(10'h000, 4'd0, -1, 1'b0, 10'h000, 4'd0, 1'b1, 30, -1);
        chk("w10_ws", ws_v, rng(0, 30));
        chk("w10_cvld", cvld_v, rng(0, 0));

        // W11: after reset, nothing in flight; start pulse at bt 1
        word(10'h000, 4'd0, -1, 1'b0, 10'h000, 4'd0, 1'b1, -1, 1);
        chk("w11_cvld", cvld_v, 64'd0);
        chk("w11_ws", ws_v, 64'd0);
        chk("w11_sync", sync_v, rng(45, 54));
        chk("w11_cflag", 64'(cflag_end), 64'd0);
`ifdef CTC_START_CHECK_EN
        exp_align = 1'b1;
`else
        exp_align = 1'b0;
`endif
        chk("w11_align", 64'(align_err), 64'(exp_align));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
